// File: rtl/uart_arb_pkg.sv
// Shared types and UART register map for the transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POLL_SETUP,
    POLL_ACCESS,
    WR_SETUP,
    WR_ACCESS
  } state_t;

  localparam logic [3:0]  RX_ADDR      = 4'h0;
  localparam logic [3:0]  TX_ADDR      = 4'h4;
  localparam logic [3:0]  CONF_ADDR    = 4'h8;
  localparam int unsigned TX_FULL_BIT  = 31;
  localparam int unsigned RX_EMPTY_BIT = 31;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after
// the last grant, wrapping, so a lone request equal to last wins after a full circle.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic                       found,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int unsigned GW = $clog2(NUM_REQ);

  always_comb begin
    found = 1'b0;
    idx   = last;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (i == (32'(last) + k) % NUM_REQ)) begin
          found = 1'b1;
          idx   = GW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between byte-stream
// requesters; acts as APB master, polling tx-full before every byte write.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 64,
  parameter logic [3:0]  TX_ADDR   = uart_arb_pkg::TX_ADDR
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [3:0]                 apb_PADDR,
  output logic                       apb_PSEL,
  output logic                       apb_PENABLE,
  output logic                       apb_PWRITE,
  output logic [31:0]                apb_PWDATA,
  input  logic                       apb_PREADY,
  input  logic [31:0]                apb_PRDATA,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  import uart_arb_pkg::*;

  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  state_t               state, state_n;
  logic                 pick_found;
  logic [GW-1:0]        pick_idx;
  logic [BW-1:0]        burst_cnt;
  logic                 last_q;
  logic                 accept;
  logic                 sel_valid;
  logic                 sel_last;
  logic [7:0]           sel_byte;
  logic [NUM_REQ-1:0]   grant_onehot;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req_valid),
    .last  (grant_id),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    sel_valid    = 1'b0;
    sel_last     = 1'b0;
    sel_byte     = '0;
    grant_onehot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GW'(i)) begin
        sel_valid       = req_valid[i];
        sel_last        = req_last[i];
        sel_byte        = req_data[8*i +: 8];
        grant_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_n     = state;
    apb_PSEL    = 1'b0;
    apb_PENABLE = 1'b0;
    req_ready   = '0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) state_n = POLL_SETUP;
      end
      POLL_SETUP: begin
        apb_PSEL = 1'b1;
        state_n  = POLL_ACCESS;
      end
      POLL_ACCESS: begin
        apb_PSEL    = 1'b1;
        apb_PENABLE = 1'b1;
        if (apb_PREADY) begin
          if (apb_PRDATA[TX_FULL_BIT]) begin
            state_n = POLL_SETUP;
          end else if (sel_valid) begin
            accept    = 1'b1;
            req_ready = grant_onehot;
            state_n   = WR_SETUP;
          end else begin
            state_n = IDLE;
          end
        end
      end
      WR_SETUP: begin
        apb_PSEL = 1'b1;
        state_n  = WR_ACCESS;
      end
      WR_ACCESS: begin
        apb_PSEL    = 1'b1;
        apb_PENABLE = 1'b1;
        if (apb_PREADY) begin
          // last and burst limit together still yield one release
          if (last_q || (burst_cnt == BW'(MAX_BURST))) state_n = IDLE;
          else                                         state_n = POLL_SETUP;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant_id   <= GW'(NUM_REQ - 1);
      burst_cnt  <= '0;
      last_q     <= 1'b0;
      apb_PADDR  <= '0;
      apb_PWRITE <= 1'b0;
      apb_PWDATA <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && pick_found) begin
        grant_id   <= pick_idx;
        burst_cnt  <= '0;
        apb_PADDR  <= TX_ADDR;
        apb_PWRITE <= 1'b0;
      end
      if (accept) begin
        apb_PWDATA <= {24'b0, sel_byte};
        last_q     <= sel_last;
        apb_PWRITE <= 1'b1;
        if (burst_cnt != BW'(MAX_BURST)) burst_cnt <= burst_cnt + 1'b1;
      end
      if (state == WR_ACCESS && state_n == POLL_SETUP) apb_PWRITE <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule
